instr_fetch_seq: RTL and testbench

//  Fetch sequencer on the read side of the instruction/program register. Samples
//  the register's DATAOUT as the fetch address, reads one word from instruction

---
 rtl/instr_fetch_seq_if.sv | 43 ++++
 rtl/instr_fetch_seq.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_seq_if
// Description : Bus bundle between the fetch sequencer and its environment:
//               program-register side (run, branch, pc_in, pc_inc),
//               instruction-memory read port (mem_*), decoder handshake
//               (instr, instr_valid, dec_ready) and status (busy, fault).
//               master = the sequencer, slave = the surrounding system.
// Ports       : run, branch, pc_in, mem_valid, mem_rdata, dec_ready
//                 -> into the sequencer
//               pc_inc, mem_addr, mem_req, instr, instr_valid, busy, fault
//                 -> out of the sequencer
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              run;
  logic              branch;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_inc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              dec_ready;
  logic              busy;
  logic              fault;

  modport master (
    input  run, branch, pc_in, mem_valid, mem_rdata, dec_ready,
    output pc_inc, mem_addr, mem_req, instr, instr_valid, busy, fault
  );

  modport slave (
    output run, branch, pc_in, mem_valid, mem_rdata, dec_ready,
    input  pc_inc, mem_addr, mem_req, instr, instr_valid, busy, fault
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_seq
// Description : Instruction fetch sequencer. Samples the program register
//               output as the fetch address, reads one word from instruction
//               memory (req/valid), hands it to the decoder (valid/ready) and
//               pulses the register's increment after every accepted read.
//               Supports branch flush and a sticky memory-timeout fault.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous reset, active low
//               bus   - instr_fetch_seq_if.master (see interface header)
// Parameters  : DATA_W  - instruction width
//               ADDR_W  - fetch address width
//               TIMEOUT - WAIT cycles without mem_valid before fault (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_seq #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_seq_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Last counter value that may still wait; reaching it without data faults.
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_t            r_state,       w_state_nxt;
  logic [ADDR_W-1:0] r_mem_addr,    w_mem_addr_nxt;
  logic              r_mem_req,     w_mem_req_nxt;
  logic [DATA_W-1:0] r_instr,       w_instr_nxt;
  logic              r_instr_valid, w_instr_valid_nxt;
  logic              r_pc_inc,      w_pc_inc_nxt;
  logic              r_busy,        w_busy_nxt;
  logic              r_fault,       w_fault_nxt;
  logic [7:0]        r_cnt,         w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mem_addr    <= '0;
      r_mem_req     <= 1'b0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_pc_inc      <= 1'b0;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
      r_cnt         <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_pc_inc      <= w_pc_inc_nxt;
      r_busy        <= w_busy_nxt;
      r_fault       <= w_fault_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_req_nxt     = r_mem_req;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = r_instr_valid;
    w_pc_inc_nxt      = 1'b0;          // increment is always a single-cycle pulse
    w_fault_nxt       = r_fault;
    w_cnt_nxt         = r_cnt;

    if ((r_state != S_IDLE) && bus.branch) begin
      // Branch wins over data, timeout and handshake. Re-entering ISSUE gives
      // the register's LOAD a cycle to settle before pc_in is sampled.
      w_mem_req_nxt     = 1'b0;
      w_instr_valid_nxt = 1'b0;
      w_cnt_nxt         = 8'd0;
      w_state_nxt       = S_ISSUE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.run && !r_fault) begin
            w_state_nxt = S_ISSUE;
          end
        end

        S_ISSUE: begin
          w_mem_addr_nxt = bus.pc_in;
          w_mem_req_nxt  = 1'b1;
          w_cnt_nxt      = 8'd0;
          w_state_nxt    = S_WAIT;
        end

        S_WAIT: begin
          if (bus.mem_valid) begin
            w_instr_nxt       = bus.mem_rdata;
            w_instr_valid_nxt = 1'b1;
            w_pc_inc_nxt      = 1'b1;  // request drops on the same edge
            w_mem_req_nxt     = 1'b0;
            w_state_nxt       = S_HOLD;
          end else if (r_cnt == c_cnt_last) begin
            w_fault_nxt   = 1'b1;
            w_mem_req_nxt = 1'b0;      // abort: memory must drop the read
            w_state_nxt   = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end

        S_HOLD: begin
          if (r_instr_valid && bus.dec_ready) begin
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = bus.run ? S_ISSUE : S_IDLE;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Registered alongside the state so busy always equals (state != IDLE).
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_req     = r_mem_req;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.pc_inc      = r_pc_inc;
  assign bus.busy        = r_busy;
  assign bus.fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_seq
// Description : Self-checking bench for instr_fetch_seq. The environment
//               models the program register, the instruction memory and the
//               decoder. Every accepted memory beat pushes the word expected
//               at the model's next fetch address into a scoreboard; a
//               separate monitor pops it on each decoder handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_seq;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_fetch_seq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem [0:1023];
  logic [DATA_W-1:0] sb [$];

  // Environment knobs, all applied at the falling edge inside cyc().
  logic              rst_k, run_k, ready_k, rand_ready, rand_lat;
  logic              force_valid, valid_always, br_on_valid, br_now;
  logic [ADDR_W-1:0] pc_reg, exp_pc, br_target;
  int                lat, wcnt, n_inc, n_acc, bad, nrise, last_t, inc0, n;
  logic              prev;
  logic [ADDR_W-1:0] addrs [0:4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: at the falling edge, drive everything the next rising edge sees.
  task automatic cyc();
    logic v;
    @(negedge clk);
    rst_n         = rst_k;
    bus.run       = run_k;
    bus.dec_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_k;
    bus.branch    = 1'b0;
    // Program register: increment pulse counts.
    if (rst_k && bus.pc_inc) begin
      pc_reg = pc_reg + ADDR_W'(1);
      n_inc++;
    end
    // Memory: answers 'lat' cycles into a request (lat 0 = never).
    if (!rst_k || !bus.mem_req) begin
      wcnt = 0;
      if (rand_lat) lat = $urandom_range(1, 4);
    end else begin
      wcnt++;
    end
    v = force_valid || valid_always || (bus.mem_req && lat != 0 && wcnt >= lat);
    bus.mem_valid = v;
    bus.mem_rdata = v ? mem[bus.mem_addr[9:0]] : DATA_W'($urandom);
    // Branch: register loads target, anything fetched but undelivered is lost.
    if (br_now || (br_on_valid && v && bus.mem_req)) begin
      bus.branch  = 1'b1;
      pc_reg      = br_target;
      exp_pc      = br_target;
      sb.delete();
      br_now      = 1'b0;
      br_on_valid = 1'b0;
    end
    if (!rst_k) begin
      sb.delete();
    end else if (bus.mem_req && v && !bus.branch) begin
      sb.push_back(mem[exp_pc[9:0]]);
      exp_pc = exp_pc + ADDR_W'(1);
      n_acc++;
    end
    bus.pc_in = pc_reg;
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] pc0);
    rst_k = 1'b0; run_k = 1'b0; force_valid = 1'b0; valid_always = 1'b0;
    br_now = 1'b0; br_on_valid = 1'b0;
    cyc();
    cyc();
    rst_k = 1'b1; pc_reg = pc0; exp_pc = pc0; n_inc = 0; n_acc = 0;
    cyc();
  endtask

  task automatic drain(input string tag);
    run_k = 1'b0;
    for (int i = 0; i < 60 && (bus.busy || sb.size() != 0); i++) cyc();
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_inc_vs_beats"}, 32'(n_inc), 32'(n_acc));
  endtask

  // Scoreboard monitor: a handshake happens at the next rising edge when
  // instr_valid && dec_ready and no branch overrides it.
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.instr_valid && bus.dec_ready && !bus.branch) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_instr: got 0x%0h expected none", bus.instr);
        end else begin
          e = sb.pop_front();
          if (bus.instr !== e) begin
            n_fail++;
            $display("FAIL instr_data: got 0x%0h expected 0x%0h", bus.instr, e);
          end
        end
      end
      if (rst_n && bus.pc_inc) begin
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL pc_inc_with_req: got mem_req=%0b expected 0", bus.mem_req);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_k = 1'b0; run_k = 1'b0; ready_k = 1'b0; rand_ready = 1'b0; rand_lat = 1'b0;
    force_valid = 1'b0; valid_always = 1'b0; br_on_valid = 1'b0; br_now = 1'b0;
    pc_reg = '0; exp_pc = '0; br_target = '0;
    lat = 1; wcnt = 0; n_inc = 0; n_acc = 0; bad = 0; prev = 1'b0;
    rst_n = 1'b0; bus.run = 1'b0; bus.branch = 1'b0; bus.pc_in = '0;
    bus.mem_valid = 1'b0; bus.mem_rdata = '0; bus.dec_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = DATA_W'($urandom);
    mem[10'h040] = 16'h64C2;

    // ---- reset state
    do_reset(16'h0040);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_pc_inc", 32'(bus.pc_inc), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);

    // ---- single fetch with 2-cycle latency, then back-pressure
    lat = 2; ready_k = 1'b0; run_k = 1'b1;
    for (int i = 0; i < 20 && !bus.mem_req; i++) cyc();
    chk("single_req", 32'(bus.mem_req), 32'd1);
    chk("single_addr", 32'(bus.mem_addr), 32'h0040);
    chk("single_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 20 && !bus.instr_valid; i++) cyc();
    chk("single_valid", 32'(bus.instr_valid), 32'd1);
    chk("single_instr", 32'(bus.instr), 32'h64C2);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h64C2 || bus.mem_req !== 1'b0) bad++;
    end
    chk("bp_unstable_cycles", 32'(bad), 32'd0);
    chk("single_pc_inc_pulses", 32'(n_inc), 32'd1);
    ready_k = 1'b1;
    for (int i = 0; i < 20 && !bus.mem_req; i++) cyc();
    chk("bp_next_req", 32'(bus.mem_req), 32'd1);
    chk("bp_next_addr", 32'(bus.mem_addr), 32'h0041);
    drain("single");

    // ---- streaming: valid always high, ready always high
    do_reset(16'h0040);
    ready_k = 1'b1; valid_always = 1'b1; run_k = 1'b1;
    nrise = 0; prev = 1'b0; last_t = 0; bad = 0;
    for (int i = 0; i < 60 && nrise < 5; i++) begin
      cyc();
      if (bus.mem_req && !prev) begin
        addrs[nrise] = bus.mem_addr;
        if (nrise > 0 && (i - last_t) != 3) bad++;
        last_t = i;
        nrise++;
      end
      prev = bus.mem_req;
    end
    run_k = 1'b0;
    chk("stream_requests", 32'(nrise), 32'd5);
    chk("stream_bad_spacing", 32'(bad), 32'd0);
    for (int k = 0; k < 5; k++)
      chk($sformatf("stream_addr%0d", k), 32'(addrs[k]), 32'h0040 + 32'(k));
    drain("stream");
    valid_always = 1'b0;
    chk("stream_pc_inc_pulses", 32'(n_inc), 32'd5);
    chk("stream_pc_final", 32'(pc_reg), 32'h0045);

    // ---- branch in the same cycle as mem_valid
    do_reset(16'h0080);
    ready_k = 1'b1; lat = 2; run_k = 1'b1; br_target = 16'h0100; br_on_valid = 1'b1;
    for (int i = 0; i < 30 && br_on_valid; i++) cyc();
    chk("br_happened", 32'(br_on_valid), 32'd0);
    inc0 = n_inc;
    cyc();
    cyc();
    chk("br_no_pc_inc", 32'(n_inc - inc0), 32'd0);
    for (int i = 0; i < 20 && !bus.mem_req; i++) cyc();
    chk("br_next_addr", 32'(bus.mem_addr), 32'h0100);
    drain("branch");
    chk("br_pc_final", 32'(pc_reg), 32'h0101);

    // ---- timeout
    do_reset(16'h0200);
    lat = 0; ready_k = 1'b1; run_k = 1'b1;
    for (int i = 0; i < 20 && !bus.mem_req; i++) cyc();
    chk("to_req", 32'(bus.mem_req), 32'd1);
    n = 0;
    while (bus.mem_req && n < 40) begin
      cyc();
      n++;
    end
    chk("to_wait_cycles", 32'(n), 32'd15);
    chk("to_fault", 32'(bus.fault), 32'd1);
    chk("to_busy", 32'(bus.busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.mem_req || !bus.fault || bus.busy) bad++;
    end
    chk("to_sticky_bad_cycles", 32'(bad), 32'd0);
    chk("to_no_pc_inc", 32'(n_inc), 32'd0);
    do_reset(16'h0000);
    chk("to_fault_cleared", 32'(bus.fault), 32'd0);

    // ---- randomized traffic: run, ready, latency and branches
    do_reset(ADDR_W'($urandom));
    rand_ready = 1'b1; rand_lat = 1'b1;
    for (int i = 0; i < 800; i++) begin
      run_k = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 39) == 0) begin
        br_now    = 1'b1;
        br_target = ADDR_W'($urandom);
      end
      cyc();
    end
    rand_ready = 1'b0; ready_k = 1'b1;
    drain("rand");
    chk("rand_enough_beats", 32'(n_acc > 20), 32'd1);
    rand_lat = 1'b0;

    // ---- reset in the middle of WAIT with mem_valid high
    lat = 0; pc_reg = 16'h0300; run_k = 1'b1;
    for (int i = 0; i < 20 && !bus.mem_req; i++) cyc();
    chk("rw_req", 32'(bus.mem_req), 32'd1);
    chk("rw_addr", 32'(bus.mem_addr), 32'h0300);
    cyc();
    cyc();
    rst_k = 1'b0; force_valid = 1'b1;
    cyc();
    cyc();
    chk("rw_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rw_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rw_instr", 32'(bus.instr), 32'd0);
    chk("rw_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rw_pc_inc", 32'(bus.pc_inc), 32'd0);
    chk("rw_busy", 32'(bus.busy), 32'd0);
    chk("rw_fault", 32'(bus.fault), 32'd0);
    rst_k = 1'b1; force_valid = 1'b0; run_k = 1'b0;
    cyc();
    cyc();
    chk("rw_still_idle", 32'(bus.busy), 32'd0);
    chk("rw_no_instr", 32'(bus.instr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
